// File: rtl/gen_event_pkg.sv
// Shared types and constants for the event-export arbiter.
// Slot fields are stored at full EVT_W width; narrower instances zero-extend on capture.
package gen_event_pkg;

    localparam int EVT_W = 64;

    // An event id of zero means "no parent".
    localparam logic [EVT_W-1:0] NO_PARENT = '0;

    typedef struct packed {
        logic [EVT_W-1:0] parent;
        logic [EVT_W-1:0] data;
        logic [EVT_W-1:0] cycle;
    } evt_slot_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: searches from the rr pointer upward with wraparound.
// The pointer moves past the winner only when the caller consumes the grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   grant_idx,
    output logic               any_grant
);

    logic [SRC_W-1:0] rr;
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Extra bit keeps rr+k from overflowing before the modulo fold.
            sum = {1'b0, rr} + (SRC_W+1)'(k);
            if (sum >= (SRC_W+1)'(NUM_REQ))
                sum = sum - (SRC_W+1)'(NUM_REQ);
            cand = sum[SRC_W-1:0];
            if (!any_grant && req[cand]) begin
                any_grant   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr <= '0;
        end else if (advance && any_grant) begin
            rr <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/gen_event_arbiter.sv
// Funnels NUM_REQ event sources into one registered export channel, stamping
// the acceptance cycle and assigning a monotonic id at grant.
module gen_event_arbiter
    import gen_event_pkg::*;
#(
    parameter int                NUM_REQ = 4,
    parameter int                DATA_W  = 64,
    parameter logic [DATA_W-1:0] ID_BASE = DATA_W'(1),
    parameter int                SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_parent,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_id,
    output logic [DATA_W-1:0]         out_parent,
    output logic [DATA_W-1:0]         out_cycle,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    output logic [DATA_W-1:0]         issued_count
);

    logic [DATA_W-1:0]             cycle_cnt;
    logic [DATA_W-1:0]             id_cnt;
    logic [NUM_REQ-1:0]            full_q;
    evt_slot_t [NUM_REQ-1:0]       slot_q;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            pop;
    logic [NUM_REQ-1:0]            accept;
    logic [SRC_W-1:0]              grant_idx;
    logic                          any_grant;
    logic                          load;
    evt_slot_t                     win;

    assign load = !out_valid || out_ready;
    assign pop  = load ? grant : '0;

    // A slot being drained this cycle can take a new request in the same cycle.
    assign req_ready = reset_n ? ({NUM_REQ{enable}} & (~full_q | pop)) : '0;
    assign accept    = req_valid & req_ready;
    assign win       = slot_q[grant_idx];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_rr (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (full_q),
        .advance   (load),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    // Capture stamps the pre-increment cycle value seen at the accepting edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= '0;
            slot_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    full_q[i]        <= 1'b1;
                    slot_q[i].parent <= EVT_W'(req_parent[i*DATA_W +: DATA_W]);
                    slot_q[i].data   <= EVT_W'(req_data[i*DATA_W +: DATA_W]);
                    slot_q[i].cycle  <= EVT_W'(cycle_cnt);
                end else if (pop[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_id       <= '0;
            out_parent   <= NO_PARENT[DATA_W-1:0];
            out_cycle    <= '0;
            out_data     <= '0;
            out_src      <= '0;
            id_cnt       <= ID_BASE;
            issued_count <= '0;
        end else if (load) begin
            if (any_grant) begin
                out_valid    <= 1'b1;
                out_id       <= id_cnt;
                out_parent   <= win.parent[DATA_W-1:0];
                out_data     <= win.data[DATA_W-1:0];
                out_cycle    <= win.cycle[DATA_W-1:0];
                out_src      <= grant_idx;
                id_cnt       <= id_cnt + 1'b1;
                issued_count <= issued_count + 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gen_event_arbiter.sv
// Bench for gen_event_arbiter: random/directed traffic on a 64-bit instance
// against an event-level model, plus id/cycle wrap on an 8-bit instance.
module tb_gen_event_arbiter;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         enable;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [255:0] req_parent;
    logic [255:0] req_data;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_id, out_parent, out_cycle, out_data, issued_count;
    logic [1:0]   out_src;

    logic         r8_n;
    logic [3:0]   v8;
    logic [3:0]   rdy8;
    logic [31:0]  p8, d8;
    logic         ov8;
    logic [7:0]   id8, par8, cyc8, dat8, iss8;
    logic [1:0]   src8;

    int tests = 0;
    int fails = 0;

    // Event-level model state
    bit          m_full [4];
    logic [63:0] m_par [4];
    logic [63:0] m_dat [4];
    logic [63:0] m_stamp [4];
    bit          m_ov;
    logic [63:0] m_id, m_parent, m_data, m_cycle, m_cnt, m_next_id, m_issued;
    int          m_src, m_rr;

    always #5 clock = ~clock;

    gen_event_arbiter dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_parent(req_parent), .req_data(req_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_parent(out_parent), .out_cycle(out_cycle),
        .out_data(out_data), .out_src(out_src), .issued_count(issued_count)
    );

    gen_event_arbiter #(.NUM_REQ(4), .DATA_W(8), .ID_BASE(8'd254)) dut8 (
        .clock(clock), .reset_n(r8_n), .enable(1'b1),
        .req_valid(v8), .req_ready(rdy8),
        .req_parent(p8), .req_data(d8),
        .out_valid(ov8), .out_ready(1'b1),
        .out_id(id8), .out_parent(par8), .out_cycle(cyc8),
        .out_data(dat8), .out_src(src8), .issued_count(iss8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_full[i] = 0;
        m_ov = 0; m_cnt = 0; m_next_id = 64'd1; m_issued = 0; m_rr = 0;
    endtask

    task automatic set_data();
        for (int i = 0; i < 4; i++) begin
            req_parent[i*64 +: 64] = {$urandom(), $urandom()};
            req_data[i*64 +: 64]   = {$urandom(), $urandom()};
        end
    endtask

    // Inputs are already driven; check, advance one edge, update the model.
    task automatic step();
        int g;
        bit load;
        logic [3:0] exp_rdy;
        #1;
        load = !m_ov || out_ready;
        g = -1;
        if (load)
            for (int k = 0; k < 4; k++)
                if (g < 0 && m_full[(m_rr + k) % 4]) g = (m_rr + k) % 4;
        for (int i = 0; i < 4; i++)
            exp_rdy[i] = enable && (!m_full[i] || g == i);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            chk("out_id", out_id, m_id);
            chk("out_parent", out_parent, m_parent);
            chk("out_data", out_data, m_data);
            chk("out_cycle", out_cycle, m_cycle);
            chk("out_src", 64'(out_src), 64'(m_src));
        end
        chk("issued_count", issued_count, m_issued);
        @(posedge clock);
        if (load) begin
            if (g >= 0) begin
                m_ov = 1; m_id = m_next_id; m_parent = m_par[g]; m_data = m_dat[g];
                m_cycle = m_stamp[g]; m_src = g; m_full[g] = 0;
                m_next_id++; m_issued++; m_rr = (g + 1) % 4;
            end else begin
                m_ov = 0;
            end
        end
        for (int i = 0; i < 4; i++)
            if (req_valid[i] && exp_rdy[i]) begin
                m_full[i] = 1;
                m_par[i] = req_parent[i*64 +: 64];
                m_dat[i] = req_data[i*64 +: 64];
                m_stamp[i] = m_cnt;
            end
        m_cnt++;
        @(negedge clock);
    endtask

    initial begin
        reset_n = 0; enable = 1; req_valid = 0; out_ready = 1;
        req_parent = '0; req_data = '0;
        r8_n = 0; v8 = 0; p8 = '0; d8 = '0;
        model_reset();
        repeat (3) @(negedge clock);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_id", out_id, 64'd0);
        @(negedge clock);
        reset_n = 1;

        // Single event stamped at cycle 5
        repeat (5) step();
        req_valid = 4'b0001; req_parent[63:0] = 64'd0; req_data[63:0] = 64'hAA;
        step();
        req_valid = 0;
        step();
        chk("t1_id", out_id, 64'd1);
        chk("t1_cycle", out_cycle, 64'd5);
        chk("t1_data", out_data, 64'hAA);
        chk("t1_src", 64'(out_src), 64'd0);
        step();

        // All sources streaming with sink always ready
        req_valid = 4'hF;
        for (int n = 0; n < 12; n++) begin set_data(); step(); end
        req_valid = 0;
        repeat (3) step();

        // Backpressure with sources 1 and 3 pending
        out_ready = 0; req_valid = 4'b1010;
        for (int n = 0; n < 12; n++) begin set_data(); step(); end
        out_ready = 1;
        for (int n = 0; n < 6; n++) begin set_data(); step(); end
        req_valid = 0;
        repeat (4) step();

        // Enable drop with slots 0 and 2 full
        out_ready = 0; req_valid = 4'b0101; set_data();
        repeat (2) step();
        req_valid = 0; enable = 0; out_ready = 1;
        repeat (5) step();
        enable = 1;

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            req_valid = 4'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 7) != 0);
            set_data();
            step();
        end

        // Asynchronous reset with the output held and all slots full
        enable = 1; out_ready = 0; req_valid = 4'hF; set_data();
        repeat (3) step();
        #3 reset_n = 0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_req_ready", 64'(req_ready), 64'd0);
        chk("arst_issued", issued_count, 64'd0);
        chk("arst_out_id", out_id, 64'd0);
        model_reset();
        req_valid = 0; out_ready = 1;
        @(negedge clock);
        reset_n = 1;
        req_valid = 4'b1100; set_data();
        step();
        req_valid = 0;
        step();
        chk("arst_first_id", out_id, 64'd1);
        chk("arst_first_src", 64'(out_src), 64'd2);
        repeat (4) step();

        // 8-bit instance: id and cycle wraparound
        @(negedge clock);
        r8_n = 1;
        repeat (253) @(negedge clock);
        v8 = 4'b0001; d8[7:0] = 8'h5C;
        @(negedge clock);
        @(negedge clock);
        chk("w_id0", 64'(id8), 64'd254);
        chk("w_cyc0", 64'(cyc8), 64'd253);
        @(negedge clock);
        chk("w_id1", 64'(id8), 64'd255);
        chk("w_cyc1", 64'(cyc8), 64'd254);
        @(negedge clock);
        chk("w_id2", 64'(id8), 64'd0);
        chk("w_cyc2", 64'(cyc8), 64'd255);
        v8 = 0;
        @(negedge clock);
        chk("w_id3", 64'(id8), 64'd1);
        chk("w_cyc3", 64'(cyc8), 64'd0);
        chk("w_data", 64'(dat8), 64'h5C);
        chk("w_src", 64'(src8), 64'd0);
        chk("w_issued", 64'(iss8), 64'd4);
        @(negedge clock);
        chk("w_drained", 64'(ov8), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
